instr_fetch: RTL and testbench

Instruction fetch stage for the RV32I core: owns the program counter, issues word reads to instruction memory, buffers returned words in a small in-order queue, and presents them with their PC to the decode/execute datapath over a valid/ready handshake. Sits directly upstream of the decode → regfile → ALU path and replaces its testbench-driven instruction input. Redirects from branch/jump resolution flush the queue and restart fetch at the new PC.

---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   NOP           : canonical RV32I no-op (addi x0, x0, 0), shown when no instruction is valid
//   fetch_state_e : fetch state machine encoding
//   next_pc()     : sequential PC step, wraps modulo 2^32
// Build option: FETCH_ALIGN_CHECK_EN adds the StFault state.
package instr_fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StRun
`ifdef FETCH_ALIGN_CHECK_EN
        , StFault
`endif
    } fetch_state_e;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read bus.
//   imem_req    : read request valid (fetch -> memory)
//   imem_addr   : word-aligned read address, held while waiting for a grant
//   imem_gnt    : request accepted this cycle
//   imem_rvalid : one in-order response per grant, at least one cycle after it
//   imem_rdata  : response data
// master = fetch stage, slave = memory.
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// In-order queue of fetched {pc, instruction} entries.
//   clk, reset : clock, asynchronous active-low reset
//   push       : write push_data at the tail
//   pop        : drop the head entry
//   flush      : empty the queue (overrides push and pop)
//   count      : number of stored entries
//   head       : oldest entry, meaningful only when count != 0
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads on the imem bus, queues returned
// words with their PC and hands them downstream over a valid/ready handshake.
//   clk, reset          : clock, asynchronous active-low reset
//   imem                : instruction memory bus (master side)
//   redirect            : restart fetch at redirect_pc, flushing everything in flight
//   redirect_pc         : redirect target
//   instr_valid/ready   : downstream handshake
//   instr, instr_pc     : head instruction (NOP when not valid) and its address (0 when not valid)
//   fetch_fault         : misaligned redirect seen (sticky until reset)
// Build option: FETCH_ALIGN_CHECK_EN traps misaligned redirects into StFault; without it the
// low two target bits are ignored and fetch_fault stays 0.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master imem,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    output logic          fetch_fault
);

    localparam int unsigned   CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW:0] Depth = (CntW+1)'(FIFO_DEPTH);

    fetch_state_e    state_q;
    logic [31:0]     pc_q;
    logic [31:0]     rsp_pc_q;      // PC of the next response that will be kept
    logic [CntW-1:0] outstanding_q;
    logic [CntW-1:0] discard_q;     // responses still owed for flushed requests
    logic [CntW-1:0] out_next;
    logic [CntW-1:0] q_count;
    logic [CntW:0]   used;
    logic [63:0]     q_head;
    logic [31:0]     target;
    logic            run, gnt_fire, push, pop, flush;

    always_comb begin
        run         = (state_q == StRun);
        instr_valid = run && (q_count != '0);
        pop         = instr_valid && instr_ready;
        // A pop this cycle frees its slot early; this is what sustains one instruction per cycle.
        used          = {1'b0, q_count} + {1'b0, outstanding_q} - (CntW+1)'(pop);
        imem.imem_req  = run && (used < Depth);
        imem.imem_addr = pc_q;
        gnt_fire    = imem.imem_req && imem.imem_gnt;
        out_next    = outstanding_q + CntW'(gnt_fire) - CntW'(imem.imem_rvalid);
        push        = run && imem.imem_rvalid && (discard_q == '0) && !redirect;
        flush       = run && redirect;
        target      = redirect_pc & 32'hFFFF_FFFC;
        instr       = instr_valid ? q_head[31:0]  : NOP;
        instr_pc    = instr_valid ? q_head[63:32] : 32'h0;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    logic misaligned;
    assign misaligned  = (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            outstanding_q <= out_next;
            if (imem.imem_rvalid && (discard_q != '0)) discard_q <= discard_q - CntW'(1);
            if (push) rsp_pc_q <= next_pc(rsp_pc_q);
            case (state_q)
                StIdle: state_q <= StRun;
                StRun: begin
                    if (gnt_fire) pc_q <= next_pc(pc_q);
                    if (redirect) begin
                        // Everything still owed after this cycle's grant/response is stale.
                        pc_q      <= target;
                        rsp_pc_q  <= target;
                        discard_q <= out_next;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misaligned) begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({rsp_pc_q, imem.imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .count     (q_count),
        .head      (q_head)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. A memory model answers the imem bus with randomised
// grant/response timing and data derived from the address; the expected consumed stream is
// the sequential PC sequence restarted at each redirect or reset.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam int          STREAM   = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    instr_fetch_if imem ();

    instr_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] pend [$];
    int          gnt_mode = 0;   // 0 always, 1 random, 2 never
    int          rv_mode = 0;    // 0 immediate, 1 random delay, 2 hold
    int          n_gnt = 0;
    int          n_hs = 0;
    bit          chk_en = 1'b0;
    logic        fault_exp = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic start_stream(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < STREAM; i++) exp_q.push_back(base + 32'(i) * 32'd4);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Redirect in cycle N; returns at the drive point of N+1.
    task automatic do_redirect(input logic [31:0] tgt, input bit to_fault);
        cyc();
        redirect    = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        #1;
        if (to_fault) begin
            exp_q.delete();
            fault_exp = 1'b1;
        end else begin
            start_stream(tgt & 32'hFFFF_FFFC);
        end
        cyc();
        redirect    = 1'b0;
        redirect_pc = $urandom;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset && chk_en) begin
            if (instr_valid && instr_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream: got instr_pc %h expected no instruction", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instr", instr, mem_word(e));
                end
            end else if (!instr_valid) begin
                check("idle_nop", instr, NOP);
            end
            check("fetch_fault", 32'(fetch_fault), 32'(fault_exp));
        end
    end

    // Memory model.
    initial begin
        logic        prev_wait;
        logic [31:0] prev_addr;
        prev_wait = 1'b0;
        prev_addr = 32'h0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend.delete();
                prev_wait = 1'b0;
            end else begin
                if (prev_wait && imem.imem_req) check("addr_stable", imem.imem_addr, prev_addr);
                prev_wait = imem.imem_req && !imem.imem_gnt && !redirect;
                prev_addr = imem.imem_addr;
                if (imem.imem_req && imem.imem_gnt) begin
                    pend.push_back(imem.imem_addr);
                    n_gnt++;
                end
            end
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       imem.imem_gnt = 1'b1;
                1:       imem.imem_gnt = ($urandom_range(0, 1) == 1);
                default: imem.imem_gnt = 1'b0;
            endcase
            if (pend.size() != 0 && (rv_mode == 0 || (rv_mode == 1 && $urandom_range(0, 2) != 0)))
            begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = mem_word(pend.pop_front());
            end else begin
                imem.imem_rvalid = 1'b0;
                imem.imem_rdata  = $urandom;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish within 200000 cycles");
        $fatal(1);
    end

    initial begin
        int          g0;
        int          h0;
        logic [31:0] saved;
        logic [31:0] tgt;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(imem.imem_req), 32'h0);
        check("rst_addr", imem.imem_addr, RESET_PC);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_fault", 32'(fetch_fault), 32'h0);
        start_stream(RESET_PC);
        chk_en = 1'b1;

        // Release between edges; cycle 1 follows the next edge.
        cyc();
        reset       = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("first_req", 32'(imem.imem_req), 32'h1);
        check("first_addr", imem.imem_addr, RESET_PC);
        @(negedge clk);
        check("valid_c2", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("full_rate", 32'(instr_valid), 32'h1);
        end

        // Downstream stall.
        cyc();
        instr_ready = 1'b0;
        g0 = n_gnt;
        repeat (10) @(negedge clk);
        check("stall_req", 32'(imem.imem_req), 32'h0);
        check("stall_valid", 32'(instr_valid), 32'h1);
        check("stall_grants", 32'((n_gnt - g0) <= int'(DEPTH)), 32'h1);
        cyc();
        instr_ready = 1'b1;
        repeat (4) cyc();

        // Grant withheld for three cycles.
        @(negedge clk);
        gnt_mode = 2;
        @(negedge clk);
        saved = imem.imem_addr;
        check("wait_req", 32'(imem.imem_req), 32'h1);
        repeat (2) begin
            @(negedge clk);
            check("wait_addr", imem.imem_addr, saved);
        end
        gnt_mode = 0;
        @(negedge clk);
        check("gnt_addr", imem.imem_addr, saved);
        check("gnt_req", 32'(imem.imem_req), 32'h1);
        @(negedge clk);
        check("gnt_advance", imem.imem_addr, saved + 32'd4);
        repeat (6) cyc();

        // Redirect with a response and a handshake in the same cycle.
        do_redirect(32'h0000_0200, 1'b0);
        @(negedge clk);
        check("rd_n1_valid", 32'(instr_valid), 32'h0);
        check("rd_n1_req", 32'(imem.imem_req), 32'h1);
        check("rd_n1_addr", imem.imem_addr, 32'h0000_0200);
        @(negedge clk);
        check("rd_n2_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        check("rd_n3_valid", 32'(instr_valid), 32'h1);
        check("rd_n3_pc", instr_pc, 32'h0000_0200);

        // Redirect with two responses outstanding.
        @(negedge clk);
        rv_mode = 2;
        repeat (6) @(negedge clk);
        check("hold_pending", 32'(pend.size()), 32'd2);
        check("hold_req", 32'(imem.imem_req), 32'h0);
        check("hold_valid", 32'(instr_valid), 32'h0);
        h0 = n_hs;
        do_redirect(32'h0000_0100, 1'b0);
        @(negedge clk);
        rv_mode = 0;
        repeat (10) @(negedge clk);
        check("flush_resume", 32'(n_hs > h0), 32'h1);

        // Randomised traffic with redirects, address wrap and one mid-run reset.
        @(negedge clk);
        gnt_mode = 1;
        rv_mode  = 1;
        h0 = n_hs;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            instr_ready = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                reset = 1'b0;
                repeat (2) cyc();
                start_stream(RESET_PC);
                reset = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                tgt = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'($urandom));
`ifdef FETCH_ALIGN_CHECK_EN
                tgt[1:0] = 2'b00;
`endif
                do_redirect(tgt, 1'b0);
            end
        end
        check("random_progress", 32'((n_hs - h0) >= 200), 32'h1);
        @(negedge clk);
        gnt_mode = 0;
        rv_mode  = 0;
        cyc();
        instr_ready = 1'b1;
        repeat (8) cyc();

        // Misaligned redirect target.
        h0 = n_hs;
`ifdef FETCH_ALIGN_CHECK_EN
        do_redirect(32'h0000_0102, 1'b1);
        @(negedge clk);
        check("mis_fault", 32'(fetch_fault), 32'h1);
        check("mis_req", 32'(imem.imem_req), 32'h0);
        check("mis_valid", 32'(instr_valid), 32'h0);
        repeat (6) @(negedge clk);
        check("mis_fault_hold", 32'(fetch_fault), 32'h1);
        check("mis_req_hold", 32'(imem.imem_req), 32'h0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("mis_fault_reset", 32'(fetch_fault), 32'h0);
`else
        do_redirect(32'h0000_0102, 1'b0);
        @(negedge clk);
        check("mis_addr", imem.imem_addr, 32'h0000_0100);
        check("mis_fault", 32'(fetch_fault), 32'h0);
        repeat (6) @(negedge clk);
        check("mis_resume", 32'(n_hs > h0), 32'h1);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
